// File: rtl/pc_seq_ctrl.sv
// Fetch/issue sequencer driving the PC block; Bcond/Jcond/JAL decode.
// Optional stop-on-16'hFFFF behaviour is enabled by defining PC_SEQ_HALT_EN.
module pc_seq_ctrl #(
    parameter int DATA_W = 16,
    parameter int DISP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] pc,
    output logic              imem_req,
    output logic [DATA_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_data,
    input  logic [4:0]        flags,
    input  logic              stall,
    output logic [3:0]        rtgt_sel,
    input  logic [DATA_W-1:0] rtgt,
    output logic              pcEn,
    output logic              branch,
    output logic              jump,
    output logic [DISP_W-1:0] disp,
    output logic [DATA_W-1:0] dDst,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic              ra_wr_en,
    output logic [3:0]        ra_wr_addr,
    output logic [DATA_W-1:0] ra_wr_data,
    output logic              halt
);

    typedef enum logic [1:0] {
        S_RESET,
        S_FETCH,
        S_ISSUE,
        S_HALT
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] instr_q, instr_d;

    logic is_bcond;
    logic is_jcond;
    logic is_jal;
    logic is_halt;
    logic take;

    // flags packing is {C,L,F,Z,N}
    function automatic logic cond_true(
        input logic [3:0] c,
        input logic [4:0] f
    );
        logic fc, fl, ff, fz, fn;
        logic r;
        {fc, fl, ff, fz, fn} = f;
        case (c)
            4'h0:    r = fz;
            4'h1:    r = !fz;
            4'h2:    r = fc;
            4'h3:    r = !fc;
            4'h4:    r = fl;
            4'h5:    r = !fl;
            4'h6:    r = fn;
            4'h7:    r = !fn;
            4'h8:    r = ff;
            4'h9:    r = !ff;
            4'hA:    r = !fl && !fz;
            4'hB:    r = fl || fz;
            4'hC:    r = !fn && !fz;
            4'hD:    r = fn || fz;
            4'hE:    r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    assign is_bcond = (instr_q[15:12] == 4'hC);
    assign is_jcond = (instr_q[15:12] == 4'h4)
                   && (instr_q[7:4] == 4'hC);
    assign is_jal   = (instr_q[15:12] == 4'h4)
                   && (instr_q[7:4] == 4'h8);
    assign take     = cond_true(instr_q[11:8], flags);

`ifdef PC_SEQ_HALT_EN
    assign is_halt = (instr_q == '1);
    assign halt    = (state_q == S_HALT);
`else
    assign is_halt = 1'b0;
    assign halt    = 1'b0;
`endif

    assign instr    = instr_q;
    assign rtgt_sel = instr_q[3:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_RESET;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        imem_req    = 1'b0;
        imem_addr   = '0;
        instr_valid = 1'b0;
        pcEn        = 1'b0;
        branch      = 1'b0;
        jump        = 1'b0;
        disp        = '0;
        dDst        = '0;
        ra_wr_en    = 1'b0;
        ra_wr_addr  = '0;
        ra_wr_data  = '0;
        unique case (state_q)
            S_RESET: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                imem_req  = 1'b1;
                imem_addr = pc;
                if (imem_ack) begin
                    instr_d = imem_data;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // a stalled issue holds everything, including the decode
                if (!stall) begin
                    instr_valid = 1'b1;
                    state_d     = S_FETCH;
                    if (is_halt) begin
                        state_d = S_HALT;
                    end else begin
                        pcEn = 1'b1;
                        if (is_bcond && take) begin
                            branch = 1'b1;
                            disp   = instr_q[DISP_W-1:0];
                        end else if (is_jcond && take) begin
                            jump = 1'b1;
                            dDst = rtgt;
                        end else if (is_jal) begin
                            jump       = 1'b1;
                            dDst       = rtgt;
                            ra_wr_en   = 1'b1;
                            ra_wr_addr = instr_q[11:8];
                            ra_wr_data = pc + DATA_W'(1);
                        end
                    end
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_RESET;
            end
        endcase
    end

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Randomized self-checking bench for pc_seq_ctrl with a behavioural
// reference of the decode and a modelled PC block.
module tb_pc_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic [4:0]  flags;
    logic        stall;
    logic [3:0]  rtgt_sel;
    logic [15:0] rtgt;
    logic        pcEn;
    logic        branch;
    logic        jump;
    logic [7:0]  disp;
    logic [15:0] dDst;
    logic [15:0] instr;
    logic        instr_valid;
    logic        ra_wr_en;
    logic [3:0]  ra_wr_addr;
    logic [15:0] ra_wr_data;
    logic        halt;

    logic [15:0] regs [16];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic        pcEn;
        logic        branch;
        logic        jump;
        logic [7:0]  disp;
        logic [15:0] dDst;
        logic        ra_wr_en;
        logic [3:0]  ra_wr_addr;
        logic [15:0] ra_wr_data;
        logic        instr_valid;
        logic [15:0] instr;
        logic [3:0]  rtgt_sel;
    } ctl_t;

    pc_seq_ctrl #(.DATA_W(16), .DISP_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_data   (imem_data),
        .flags       (flags),
        .stall       (stall),
        .rtgt_sel    (rtgt_sel),
        .rtgt        (rtgt),
        .pcEn        (pcEn),
        .branch      (branch),
        .jump        (jump),
        .disp        (disp),
        .dDst        (dDst),
        .instr       (instr),
        .instr_valid (instr_valid),
        .ra_wr_en    (ra_wr_en),
        .ra_wr_addr  (ra_wr_addr),
        .ra_wr_data  (ra_wr_data),
        .halt        (halt)
    );

    assign rtgt = regs[rtgt_sel];

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference decode straight from the instruction-set rules.
    function automatic ctl_t ref_model(
        input logic [15:0] ins,
        input logic [4:0]  fl,
        input logic [15:0] pcv
    );
        ctl_t        e;
        logic        C, L, F, Z, N;
        logic [15:0] truth;
        logic        ct;
        logic [15:0] lnk;
        C = fl[4]; L = fl[3]; F = fl[2]; Z = fl[1]; N = fl[0];
        truth = {1'b0, 1'b1, N | Z, !N & !Z, L | Z, !L & !Z, !F, F,
                 !N, N, !L, L, !C, C, !Z, Z};
        ct  = truth[ins[11:8]];
        lnk = pcv + 16'd1;
        e = '0;
        e.pcEn        = 1'b1;
        e.instr_valid = 1'b1;
        e.instr       = ins;
        e.rtgt_sel    = ins[3:0];
        if (ins[15:12] == 4'hC && ct) begin
            e.branch = 1'b1;
            e.disp   = ins[7:0];
        end
        if (ins[15:12] == 4'h4 && ins[7:4] == 4'hC && ct) begin
            e.jump = 1'b1;
            e.dDst = regs[ins[3:0]];
        end
        if (ins[15:12] == 4'h4 && ins[7:4] == 4'h8) begin
            e.jump       = 1'b1;
            e.dDst       = regs[ins[3:0]];
            e.ra_wr_en   = 1'b1;
            e.ra_wr_addr = ins[11:8];
            e.ra_wr_data = lnk;
        end
        return e;
    endfunction

    // Drives one fetch/issue; entered and left at posedge+1 in FETCH.
    task automatic drive_instr(
        input  logic [15:0] ins,
        input  logic [4:0]  fl,
        input  int          ack_dly,
        input  int          stall_n,
        output ctl_t        got,
        output ctl_t        exp_v,
        output int          req_bad,
        output int          stall_bad,
        output logic        issue_req
    );
        logic [15:0] nxt;
        req_bad   = 0;
        stall_bad = 0;
        for (int i = 0; i <= ack_dly; i++) begin
            imem_ack  = (i == ack_dly);
            imem_data = (i == ack_dly) ? ins : 16'($urandom);
            #2;
            if (imem_req !== 1'b1 || imem_addr !== pc) req_bad++;
            @(posedge clk); #1;
        end
        imem_ack  = 1'b0;
        imem_data = 16'($urandom);
        for (int i = 0; i < stall_n; i++) begin
            stall = 1'b1;
            flags = 5'($urandom);
            #2;
            if ({pcEn, branch, jump, ra_wr_en, instr_valid} !== 5'b0)
                stall_bad++;
            if (instr !== ins || imem_req !== 1'b0) stall_bad++;
            @(posedge clk); #1;
        end
        stall = 1'b0;
        flags = fl;
        #2;
        exp_v = ref_model(ins, fl, pc);
        got.pcEn        = pcEn;
        got.branch      = branch;
        got.jump        = jump;
        got.disp        = disp;
        got.dDst        = dDst;
        got.ra_wr_en    = ra_wr_en;
        got.ra_wr_addr  = ra_wr_en ? ra_wr_addr : 4'h0;
        got.ra_wr_data  = ra_wr_en ? ra_wr_data : 16'h0;
        got.instr_valid = instr_valid;
        got.instr       = instr;
        got.rtgt_sel    = rtgt_sel;
        issue_req       = imem_req;
        nxt = pc + 16'd1;
        if (branch) nxt = pc + {{8{disp[7]}}, disp};
        else if (jump) nxt = dDst;
        @(posedge clk); #1;
        if (got.pcEn) pc = nxt;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        n_checks++;
        if ({imem_req, imem_addr, pcEn, branch, jump, disp, dDst, instr,
             instr_valid, ra_wr_en, ra_wr_addr, ra_wr_data, halt,
             rtgt_sel} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got req=%b pcEn=%b instr=%h, required all zero",
                     imem_req, pcEn, instr);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        n_checks++;
        if (imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_first_edge: imem_req=%b required 0", imem_req);
        end
        @(posedge clk); #1;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== pc) begin
            n_fail++;
            $display("FAIL reset_to_fetch: req=%b addr=%h required 1/%h",
                     imem_req, imem_addr, pc);
        end
    endtask

    task automatic test_sequential();
        ctl_t g, e;
        int   rb, sb;
        logic ir;
        pc = 16'h0000;
        for (int k = 0; k < 4; k++) begin
            drive_instr(16'h0000, 5'($urandom), 0, 0, g, e, rb, sb, ir);
            n_checks++;
            if (g !== e || rb != 0 || ir !== 1'b0) begin
                n_fail++;
                $display("FAIL seq_%0d: got %h reqbad=%0d issreq=%b required %h",
                         k, g, rb, ir, e);
            end
        end
        n_checks++;
        if (pc !== 16'h0004 || imem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL seq_pc: pc=%h req=%b required 0004/1", pc, imem_req);
        end
    endtask

    task automatic test_bcond();
        ctl_t g, e;
        int   rb, sb;
        logic ir;
        pc = 16'h0100;
        drive_instr(16'hC07F, 5'b00010, 0, 0, g, e, rb, sb, ir);
        n_checks++;
        if (g !== e || g.branch !== 1'b1 || g.disp !== 8'h7F) begin
            n_fail++;
            $display("FAIL bcond_taken: got %h required %h", g, e);
        end
        n_checks++;
        if (pc !== 16'h017F) begin
            n_fail++;
            $display("FAIL bcond_target: pc=%h required 017F", pc);
        end
        drive_instr(16'hC07F, 5'b11101, 1, 0, g, e, rb, sb, ir);
        n_checks++;
        if (g !== e || g.branch !== 1'b0 || g.pcEn !== 1'b1) begin
            n_fail++;
            $display("FAIL bcond_not_taken: got %h required %h", g, e);
        end
    endtask

    task automatic test_jal();
        ctl_t g, e;
        int   rb, sb;
        logic ir;
        pc      = 16'hFFFF;
        regs[3] = 16'h8000;
        drive_instr(16'h4E83, 5'($urandom), 0, 0, g, e, rb, sb, ir);
        n_checks++;
        if (g !== e || g.jump !== 1'b1 || g.dDst !== 16'h8000 ||
            g.ra_wr_addr !== 4'hE || g.ra_wr_data !== 16'h0000) begin
            n_fail++;
            $display("FAIL jal_wrap: got %h required %h", g, e);
        end
    endtask

    task automatic test_jcond_stall();
        ctl_t g, e;
        int   rb, sb;
        logic ir;
        pc      = 16'h0200;
        regs[5] = 16'h1234;
        drive_instr(16'h4EC5, 5'b00000, 2, 3, g, e, rb, sb, ir);
        n_checks++;
        if (sb != 0) begin
            n_fail++;
            $display("FAIL jcond_stall_hold: %0d bad stall cycles, required 0", sb);
        end
        n_checks++;
        if (g !== e || g.jump !== 1'b1 || g.dDst !== 16'h1234 || rb != 0) begin
            n_fail++;
            $display("FAIL jcond_release: got %h reqbad=%0d required %h", g, rb, e);
        end
    endtask

    task automatic test_reset_midfetch();
        int rb;
        rb = 0;
        pc = 16'h0042;
        imem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #2;
            if (imem_req !== 1'b1 || imem_addr !== 16'h0042) rb++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (rb != 0) begin
            n_fail++;
            $display("FAIL midfetch_wait: %0d bad request cycles, required 0", rb);
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (imem_req !== 1'b0 || pcEn !== 1'b0) begin
            n_fail++;
            $display("FAIL midfetch_abort: req=%b pcEn=%b required 0/0", imem_req, pcEn);
        end
        imem_ack  = 1'b1;
        imem_data = 16'hC0AA;
        @(posedge clk); #1;
        rst = 1'b0;
        pc  = 16'h0077;
        @(posedge clk); #1;
        imem_ack = 1'b0;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0077 ||
            instr !== 16'h0000 || pcEn !== 1'b0) begin
            n_fail++;
            $display("FAIL midfetch_restart: req=%b addr=%h instr=%h pcEn=%b required 1/0077/0000/0",
                     imem_req, imem_addr, instr, pcEn);
        end
        @(posedge clk); #1;
        n_checks++;
        if (imem_req !== 1'b1 || instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midfetch_stale_ack: req=%b valid=%b required 1/0",
                     imem_req, instr_valid);
        end
    endtask

    task automatic test_random();
        ctl_t        g, e;
        int          rb, sb;
        logic        ir;
        logic [15:0] ins;
        for (int k = 0; k < 60; k++) begin
            for (int r = 0; r < 16; r++) regs[r] = 16'($urandom);
            ins = 16'($urandom);
            case ($urandom_range(0, 3))
                0: ins[15:12] = 4'hC;
                1: begin ins[15:12] = 4'h4; ins[7:4] = 4'hC; end
                2: begin ins[15:12] = 4'h4; ins[7:4] = 4'h8; end
                default: ;
            endcase
`ifdef PC_SEQ_HALT_EN
            if (ins == 16'hFFFF) ins = 16'h0000;
`endif
            if ($urandom_range(0, 3) == 0) pc = 16'($urandom);
            drive_instr(ins, 5'($urandom), $urandom_range(0, 3),
                        $urandom_range(0, 2), g, e, rb, sb, ir);
            n_checks++;
            if (g !== e || rb != 0 || sb != 0 || ir !== 1'b0 ||
                (g.branch && g.jump)) begin
                n_fail++;
                $display("FAIL random_%0d ins=%h: got %h reqbad=%0d stallbad=%0d required %h",
                         k, ins, g, rb, sb, e);
            end
        end
    endtask

`ifdef PC_SEQ_HALT_EN
    task automatic test_halt();
        int bad;
        bad = 0;
        imem_ack  = 1'b1;
        imem_data = 16'hFFFF;
        #2;
        @(posedge clk); #1;
        imem_ack = 1'b0;
        #2;
        n_checks++;
        if (pcEn !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_issue: pcEn=%b required 0", pcEn);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            imem_ack = 1'b1;
            #1;
            if (halt !== 1'b1 || pcEn !== 1'b0 || imem_req !== 1'b0) bad++;
        end
        imem_ack = 1'b0;
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL halt_hold: %0d bad cycles, required 0", bad);
        end
    endtask
`endif

    initial begin
        rst       = 1'b1;
        pc        = 16'h0000;
        imem_ack  = 1'b0;
        imem_data = 16'h0000;
        flags     = 5'h00;
        stall     = 1'b0;
        for (int r = 0; r < 16; r++) regs[r] = 16'h0000;
        test_reset();
        test_sequential();
        test_bcond();
        test_jal();
        test_jcond_stall();
        test_reset_midfetch();
        test_random();
`ifdef PC_SEQ_HALT_EN
        test_halt();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_seq_ctrl.md
Name: pc_seq_ctrl

Overview:
Fetch/sequencing controller that drives the program counter's control inputs (pcEn, branch, jump, disp, dDst) and consumes its pc output.
- Fetches the instruction at pc from instruction memory over a req/ack handshake.
- Decodes Bcond/Jcond/JAL and evaluates the condition against the processor flags.
- Issues exactly one PC update per instruction.
- Sits between the pc block, the instruction memory port and the register file / datapath.

Parameters:
DATA_W, 16, instruction/address width
DISP_W, 8, branch displacement width (matches IMMWIDTH)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
pc  in  16  current PC from the pc block
imem_req  out  1  instruction fetch request
imem_addr  out  16  fetch address (equals pc while imem_req=1)
imem_ack  in  1  fetch data valid this cycle
imem_data  in  16  fetched instruction
flags  in  5  {C,L,F,Z,N} from the PSR
stall  in  1  datapath hold request
rtgt_sel  out  4  register-file read address for the jump target (instr[3:0])
rtgt  in  16  register value for rtgt_sel (combinational, same cycle)
pcEn  out  1  PC update enable
branch  out  1  PC <= pc + sext(disp)
jump  out  1  PC <= dDst
disp  out  8  branch displacement
dDst  out  16  jump destination
instr  out  16  latched instruction
instr_valid  out  1  instr is being issued this cycle
ra_wr_en  out  1  link-register write strobe (JAL)
ra_wr_addr  out  4  link register (instr[11:8])
ra_wr_data  out  16  pc + 1
halt  out  1  sequencer halted (only with the optional feature)

Behaviour:
- Reset (async, rst=1):
  - All outputs go to 0; state=RESET. rst is an asynchronous, active-high reset.
  - An in-flight fetch is aborted; an imem_ack arriving during reset is ignored.
- States and transitions:
  - RESET: on the first clk edge with rst=0, go to FETCH.
  - FETCH: imem_req=1, imem_addr=pc. On imem_ack=1, latch imem_data into instr and go to ISSUE. imem_ack outside FETCH is ignored.
  - ISSUE (stall=0): instr_valid=1, pcEn=1 for exactly this cycle, then go to FETCH.
  - ISSUE (stall=1): remain in ISSUE with pcEn=0, branch=0, jump=0, ra_wr_en=0 and instr held.
  - HALT: present only with the optional feature.
- Minimum 2 cycles per instruction (ack in the first FETCH cycle). No PC update occurs outside ISSUE.
- Decode (ISSUE only; combinational from instr and flags):
  - Bcond, instr[15:12]=4'hC: when cond(instr[11:8]) is true, branch=1 and disp=instr[7:0].
  - Jcond, instr[15:12]=4'h4 and instr[7:4]=4'hC: when cond is true, jump=1 and dDst=rtgt.
  - JAL, instr[15:12]=4'h4 and instr[7:4]=4'h8: unconditional. jump=1, dDst=rtgt, ra_wr_en=1, ra_wr_addr=instr[11:8], ra_wr_data=pc+1 (wraps 16'hFFFF -> 16'h0000).
  - Any other instruction, or a false condition: branch=0, jump=0, pcEn=1 (sequential increment).
  - rtgt_sel=instr[3:0] at all times.
  - branch and jump are never both 1.
  - disp and dDst are 0 whenever branch or jump respectively is 0.
- Condition codes (cond field -> true when):
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 CS: C
  - 3 CC: !C
  - 4 HI: L
  - 5 LS: !L
  - 6 GT: N
  - 7 LE: !N
  - 8 FS: F
  - 9 FC: !F
  - A LO: !L&!Z
  - B HS: L|Z
  - C LT: !N&!Z
  - D GE: N|Z
  - E UC: 1
  - F: never true
- Flags are sampled in the ISSUE cycle in which pcEn is asserted (the cycle after stall drops).

Optional Feature:
Macro PC_SEQ_HALT_EN.
- Defined: instr=16'hFFFF in ISSUE asserts pcEn=0 and enters HALT. In HALT, halt=1, imem_req=0 and pcEn=0. Only rst exits HALT.
- Undefined: 16'hFFFF decodes as a non-control instruction (pc increments). The halt port is tied to 0.

Test Plan:
- Reset then sequential fetch: pc=0, imem_data=16'h0000, ack immediately -> imem_req at pc 0; one ISSUE cycle with pcEn=1, branch=0, jump=0; repeat, with a new fetch every 2 cycles.
- Bcond EQ, Z=1, instr=16'hC07F -> branch=1, disp=8'h7F, pcEn=1. Same with Z=0 -> branch=0, pcEn=1.
- JAL instr=16'h4E83, rtgt=16'h8000, pc=16'hFFFF -> jump=1, dDst=16'h8000, ra_wr_en=1, ra_wr_addr=4'hE, ra_wr_data=16'h0000.
- Jcond UC instr=16'h4EC5, rtgt=16'h1234 with stall=1 for 3 cycles -> pcEn=0 for 3 cycles; then a single cycle of jump=1, dDst=16'h1234.
- Delayed ack for 4 cycles, then rst pulsed mid-FETCH -> imem_req drops immediately; after rst=0, fetch restarts from the current pc; a stale ack is ignored.
- With PC_SEQ_HALT_EN, instr=16'hFFFF -> halt=1, pcEn stays 0 and imem_req stays 0 for 10 cycles.
